// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause 22 MDIO responder.
package mdio_pkg;

    typedef enum logic [2:0] {
        StPre,
        StSt,
        StOp,
        StPhyad,
        StRegad,
        StTa,
        StData
    } mdio_state_e;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    localparam int unsigned PHYAD_W      = 5;
    localparam int unsigned REGAD_W      = 5;
    localparam int unsigned DATA_W       = 16;
    localparam int unsigned NUM_REGS     = 32;
    localparam int unsigned MDIO_PRE_LEN = 32;

endpackage

// File: rtl/mdio_edge_sync.sv
// Synchronises MDC and MDIO into the system clock and flags MDC edges.
// Both inputs share the same flop depth so each MDIO sample lines up with its MDC edge.
module mdio_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic mdc_i,
    input  logic mdio_i,
    output logic mdc_rise_o,
    output logic mdc_fall_o,
    output logic mdio_o
);

    logic [SYNC_STAGES-1:0] mdc_sync_q;
    logic [SYNC_STAGES-1:0] mdio_sync_q;
    logic                   mdc_prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mdc_sync_q  <= '0;
            mdio_sync_q <= '0;
            mdc_prev_q  <= 1'b0;
        end else begin
            mdc_sync_q  <= {mdc_sync_q[SYNC_STAGES-2:0], mdc_i};
            mdio_sync_q <= {mdio_sync_q[SYNC_STAGES-2:0], mdio_i};
            mdc_prev_q  <= mdc_sync_q[SYNC_STAGES-1];
        end
    end

    assign mdc_rise_o = mdc_sync_q[SYNC_STAGES-1] & ~mdc_prev_q;
    assign mdc_fall_o = ~mdc_sync_q[SYNC_STAGES-1] & mdc_prev_q;
    assign mdio_o     = mdio_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/mdio_responder.sv
// Clause 22 MDIO PHY-side responder with a 32 x 16-bit register file.
// Optional MDIO_PREAMBLE_SUPPRESS_EN lets a frame follow a clean frame without preamble.
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR     = 5'd0,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned MIN_PREAMBLE = MDIO_PRE_LEN,
    parameter logic [15:0] REG0_RESET   = 16'h1140,
    parameter logic [31:0] REG_RO_MASK  = 32'h0000_0002
) (
    input  logic        rgmii_clk_in,
    input  logic        sys_rst,
    input  logic        mdc_in,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_t,
    output logic        wr_valid,
    output logic [4:0]  wr_regad,
    output logic [15:0] wr_data,
    output logic        rd_valid,
    output logic        frame_err,
    output logic [15:0] ctrl_reg
);

    localparam logic [5:0] MinPre = 6'(MIN_PREAMBLE);

    logic mdc_rise, mdc_fall, mdio_s;

    mdio_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk_i     (rgmii_clk_in),
        .rst_i     (sys_rst),
        .mdc_i     (mdc_in),
        .mdio_i    (mdio_i),
        .mdc_rise_o(mdc_rise),
        .mdc_fall_o(mdc_fall),
        .mdio_o    (mdio_s)
    );

    mdio_state_e         state_q, state_d;
    logic [5:0]          pre_cnt_q, pre_cnt_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   fld_q, fld_d, fld_shift;
    logic                is_read_q, is_read_d;
    logic                match_q, match_d;
    logic [REGAD_W-1:0]  regad_q, regad_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic                drv_q, drv_d;
    logic [4:0]          rd_left_q, rd_left_d;
    logic [DATA_W:0]     rd_sh_q, rd_sh_d;
    logic                mdio_o_q, mdio_o_d;
    logic                mdio_t_q, mdio_t_d;
    logic                wr_valid_q, wr_valid_d;
    logic [REGAD_W-1:0]  wr_regad_q, wr_regad_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                frame_err_q, frame_err_d;
    logic                err;
    logic                fast_st;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    logic sup_ok_q, sup_ok_d;
    assign fast_st = sup_ok_q;
`else
    assign fast_st = 1'b0;
`endif

    assign fld_shift = {fld_q[DATA_W-2:0], mdio_s};

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        fld_d       = fld_q;
        is_read_d   = is_read_q;
        match_d     = match_q;
        regad_d     = regad_q;
        regs_d      = regs_q;
        drv_d       = drv_q;
        rd_left_d   = rd_left_q;
        rd_sh_d     = rd_sh_q;
        mdio_o_d    = mdio_o_q;
        mdio_t_d    = mdio_t_q;
        wr_valid_d  = 1'b0;
        wr_regad_d  = wr_regad_q;
        wr_data_d   = wr_data_q;
        rd_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        err         = 1'b0;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        sup_ok_d    = sup_ok_q;
`endif

        if (mdc_rise) begin
            unique case (state_q)
                StPre: begin
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
                    // Skipping the preamble is only allowed on the very first PRE bit.
                    sup_ok_d = 1'b0;
`endif
                    if (mdio_s) begin
                        if (pre_cnt_q != 6'd63) pre_cnt_d = pre_cnt_q + 6'd1;
                    end else if (pre_cnt_q >= MinPre || fast_st) begin
                        state_d   = StSt;
                        pre_cnt_d = '0;
                    end else begin
                        pre_cnt_d = '0;
                    end
                end
                StSt: begin
                    if (mdio_s) begin
                        state_d   = StOp;
                        bit_cnt_d = '0;
                    end else begin
                        err = 1'b1;
                    end
                end
                StOp: begin
                    fld_d = fld_shift;
                    if (bit_cnt_q == 4'd1) begin
                        bit_cnt_d = '0;
                        state_d   = StPhyad;
                        if (fld_shift[1:0] == OP_WRITE) is_read_d = 1'b0;
                        else if (fld_shift[1:0] == OP_READ) is_read_d = 1'b1;
                        else err = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                StPhyad: begin
                    fld_d = fld_shift;
                    if (bit_cnt_q == 4'(PHYAD_W - 1)) begin
                        match_d   = (fld_shift[PHYAD_W-1:0] == PHY_ADDR);
                        bit_cnt_d = '0;
                        state_d   = StRegad;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                StRegad: begin
                    fld_d = fld_shift;
                    if (bit_cnt_q == 4'(REGAD_W - 1)) begin
                        regad_d   = fld_shift[REGAD_W-1:0];
                        // Leading 0 is the PHY's half of the turnaround.
                        rd_sh_d   = {1'b0, regs_q[fld_shift[REGAD_W-1:0]]};
                        bit_cnt_d = '0;
                        state_d   = StTa;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                StTa: begin
                    if (bit_cnt_q == 4'd0) begin
                        bit_cnt_d = 4'd1;
                        if (!is_read_q && !mdio_s) begin
                            err = 1'b1;
                        end else if (is_read_q && match_q) begin
                            drv_d     = 1'b1;
                            rd_left_d = 5'(DATA_W + 1);
                        end
                    end else if (!is_read_q && mdio_s) begin
                        err = 1'b1;
                    end else begin
                        bit_cnt_d = '0;
                        state_d   = StData;
                    end
                end
                StData: begin
                    fld_d = fld_shift;
                    if (bit_cnt_q == 4'(DATA_W - 1)) begin
                        state_d   = StPre;
                        pre_cnt_d = '0;
                        bit_cnt_d = '0;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
                        sup_ok_d  = 1'b1;
`endif
                        if (!is_read_q && match_q && !REG_RO_MASK[regad_q]) begin
                            regs_d[regad_q] = fld_shift;
                            wr_valid_d      = 1'b1;
                            wr_regad_d      = regad_q;
                            wr_data_d       = fld_shift;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                default: state_d = StPre;
            endcase
        end

        if (err) begin
            frame_err_d = 1'b1;
            state_d     = StPre;
            pre_cnt_d   = '0;
            bit_cnt_d   = '0;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
            sup_ok_d    = 1'b0;
`endif
        end

        if (mdc_fall && drv_q) begin
            if (rd_left_q != 5'd0) begin
                mdio_t_d   = 1'b0;
                mdio_o_d   = rd_sh_q[DATA_W];
                rd_sh_d    = {rd_sh_q[DATA_W-1:0], 1'b0};
                rd_left_d  = rd_left_q - 5'd1;
                rd_valid_d = (rd_left_q == 5'd1);
            end else begin
                mdio_t_d = 1'b1;
                mdio_o_d = 1'b0;
                drv_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge rgmii_clk_in) begin
        if (sys_rst) begin
            state_q     <= StPre;
            pre_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            fld_q       <= '0;
            is_read_q   <= 1'b0;
            match_q     <= 1'b0;
            regad_q     <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= (i == 0) ? REG0_RESET : '0;
            drv_q       <= 1'b0;
            rd_left_q   <= '0;
            rd_sh_q     <= '0;
            mdio_o_q    <= 1'b0;
            mdio_t_q    <= 1'b1;
            wr_valid_q  <= 1'b0;
            wr_regad_q  <= '0;
            wr_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
            sup_ok_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            fld_q       <= fld_d;
            is_read_q   <= is_read_d;
            match_q     <= match_d;
            regad_q     <= regad_d;
            regs_q      <= regs_d;
            drv_q       <= drv_d;
            rd_left_q   <= rd_left_d;
            rd_sh_q     <= rd_sh_d;
            mdio_o_q    <= mdio_o_d;
            mdio_t_q    <= mdio_t_d;
            wr_valid_q  <= wr_valid_d;
            wr_regad_q  <= wr_regad_d;
            wr_data_q   <= wr_data_d;
            rd_valid_q  <= rd_valid_d;
            frame_err_q <= frame_err_d;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
            sup_ok_q    <= sup_ok_d;
`endif
        end
    end

    assign mdio_o    = mdio_o_q;
    assign mdio_t    = mdio_t_q;
    assign wr_valid  = wr_valid_q;
    assign wr_regad  = wr_regad_q;
    assign wr_data   = wr_data_q;
    assign rd_valid  = rd_valid_q;
    assign frame_err = frame_err_q;
    assign ctrl_reg  = regs_q[0];

endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench for mdio_responder acting as a station manager on MDC/MDIO.
module tb_mdio_responder;
    import mdio_pkg::*;

    localparam int HALF = 5;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam bit SUP = 1'b1;
`else
    localparam bit SUP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mdc = 1'b0;
    logic        mdio_drv = 1'b1;
    logic        mdio_o, mdio_t, wr_valid, rd_valid, frame_err;
    logic [4:0]  wr_regad;
    logic [15:0] wr_data, ctrl_reg;

    always #5 clk = ~clk;

    mdio_responder dut (
        .rgmii_clk_in(clk),
        .sys_rst     (rst),
        .mdc_in      (mdc),
        .mdio_i      (mdio_drv),
        .mdio_o      (mdio_o),
        .mdio_t      (mdio_t),
        .wr_valid    (wr_valid),
        .wr_regad    (wr_regad),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .frame_err   (frame_err),
        .ctrl_reg    (ctrl_reg)
    );

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, t_low_clks = 0;
    logic bitq[$];
    logic samp_o[$];
    logic samp_t[$];

    always @(negedge clk) begin
        if (wr_valid) wr_cnt++;
        if (rd_valid) rd_cnt++;
        if (frame_err) err_cnt++;
        if (mdio_t === 1'b0) t_low_clks++;
    end

    task automatic send_bit(input logic b);
        mdio_drv = b;
        repeat (HALF) @(negedge clk);
        samp_o.push_back(mdio_o);
        samp_t.push_back(mdio_t);
        mdc = 1'b1;
        repeat (HALF) @(negedge clk);
        mdc = 1'b0;
    endtask

    task automatic build(input int npre, input logic [1:0] op, input logic [4:0] phy,
                         input logic [4:0] regad, input logic [1:0] ta, input logic [15:0] data);
        bitq.delete();
        samp_o.delete();
        samp_t.delete();
        for (int i = 0; i < npre; i++) bitq.push_back(1'b1);
        bitq.push_back(1'b0);
        bitq.push_back(1'b1);
        for (int i = 1; i >= 0; i--) bitq.push_back(op[i]);
        for (int i = 4; i >= 0; i--) bitq.push_back(phy[i]);
        for (int i = 4; i >= 0; i--) bitq.push_back(regad[i]);
        for (int i = 1; i >= 0; i--) bitq.push_back(ta[i]);
        for (int i = 15; i >= 0; i--) bitq.push_back(data[i]);
    endtask

    task automatic run_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(bitq[i]);
        mdio_drv = 1'b1;
    endtask

    task automatic write_frame(input int npre, input logic [4:0] phy, input logic [4:0] regad,
                               input logic [15:0] data);
        build(npre, OP_WRITE, phy, regad, 2'b10, data);
        run_bits(bitq.size());
        repeat (HALF) @(negedge clk);
    endtask

    // Word is the 17 values seen by the station: the turnaround bit then D15..D0.
    task automatic read_frame(input int npre, input logic [4:0] phy, input logic [4:0] regad,
                              output logic [16:0] word, output int tlow);
        build(npre, OP_READ, phy, regad, 2'b11, 16'hFFFF);
        run_bits(bitq.size());
        repeat (HALF) @(negedge clk);
        tlow = 0;
        for (int i = 0; i < samp_t.size(); i++) if (samp_t[i] === 1'b0) tlow++;
        for (int k = 0; k < 17; k++) word[16-k] = samp_o[npre + 15 + k];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (mdio_t !== 1'b1) begin errors++; $display("FAIL reset_mdio_t got %b exp 1", mdio_t); end
        checks++; if (mdio_o !== 1'b0) begin errors++; $display("FAIL reset_mdio_o got %b exp 0", mdio_o); end
        checks++; if ({wr_valid, rd_valid, frame_err} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses got %b exp 000", {wr_valid, rd_valid, frame_err}); end
        checks++; if ({wr_regad, wr_data} !== 21'h0) begin
            errors++; $display("FAIL reset_wr_fields got %h exp 0", {wr_regad, wr_data}); end
        checks++; if (ctrl_reg !== 16'h1140) begin
            errors++; $display("FAIL reset_ctrl_reg got %h exp 1140", ctrl_reg); end
    endtask

    task automatic test_write_reg0();
        int w0, t0;
        w0 = wr_cnt; t0 = t_low_clks;
        write_frame(32, 5'd0, 5'd0, 16'h1140);
        checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL wr0_pulse got %0d exp 1", wr_cnt - w0); end
        checks++; if (wr_regad !== 5'd0) begin errors++; $display("FAIL wr0_regad got %h exp 0", wr_regad); end
        checks++; if (wr_data !== 16'h1140) begin errors++; $display("FAIL wr0_data got %h exp 1140", wr_data); end
        checks++; if (t_low_clks - t0 !== 0) begin errors++; $display("FAIL wr0_tristate got %0d exp 0", t_low_clks - t0); end
        w0 = wr_cnt;
        write_frame(32, 5'd0, 5'd0, 16'h2100);
        checks++; if (ctrl_reg !== 16'h2100) begin errors++; $display("FAIL wr0_ctrl_reg got %h exp 2100", ctrl_reg); end
        checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL wr0b_pulse got %0d exp 1", wr_cnt - w0); end
    endtask

    task automatic test_read();
        logic [16:0] word;
        int tlow, r0, w0, t0;
        write_frame(32, 5'd0, 5'd4, 16'hABCD);
        checks++; if (wr_regad !== 5'd4 || wr_data !== 16'hABCD) begin
            errors++; $display("FAIL rd_prewrite got %h/%h exp 4/abcd", wr_regad, wr_data); end
        r0 = rd_cnt; w0 = wr_cnt; t0 = t_low_clks;
        read_frame(32, 5'd0, 5'd4, word, tlow);
        checks++; if (word !== {1'b0, 16'hABCD}) begin errors++; $display("FAIL rd_bits got %h exp %h", word, {1'b0, 16'hABCD}); end
        checks++; if (tlow !== 17) begin errors++; $display("FAIL rd_drive_periods got %0d exp 17", tlow); end
        checks++; if (t_low_clks - t0 !== 17 * 2 * HALF) begin
            errors++; $display("FAIL rd_drive_clks got %0d exp %0d", t_low_clks - t0, 17 * 2 * HALF); end
        checks++; if (rd_cnt - r0 !== 1) begin errors++; $display("FAIL rd_valid_count got %0d exp 1", rd_cnt - r0); end
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL rd_no_write got %0d exp 0", wr_cnt - w0); end
        checks++; if (mdio_t !== 1'b1) begin errors++; $display("FAIL rd_release got %b exp 1", mdio_t); end
    endtask

    task automatic test_phyad_mismatch();
        logic [16:0] word;
        int tlow, r0, w0, t0;
        w0 = wr_cnt; r0 = rd_cnt; t0 = t_low_clks;
        write_frame(32, 5'd1, 5'd0, 16'h1234);
        read_frame(32, 5'd1, 5'd4, word, tlow);
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL mis_write got %0d exp 0", wr_cnt - w0); end
        checks++; if (ctrl_reg !== 16'h2100) begin errors++; $display("FAIL mis_ctrl_reg got %h exp 2100", ctrl_reg); end
        checks++; if (t_low_clks - t0 !== 0) begin errors++; $display("FAIL mis_tristate got %0d exp 0", t_low_clks - t0); end
        checks++; if (rd_cnt - r0 !== 0) begin errors++; $display("FAIL mis_rd_valid got %0d exp 0", rd_cnt - r0); end
    endtask

    task automatic test_errors();
        int e0, w0;
        e0 = err_cnt; w0 = wr_cnt;
        build(32, 2'b00, 5'd0, 5'd3, 2'b10, 16'h0000);
        run_bits(36);
        repeat (HALF) @(negedge clk);
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL op00_err got %0d exp 1", err_cnt - e0); end
        e0 = err_cnt;
        build(32, 2'b11, 5'd0, 5'd3, 2'b10, 16'h0000);
        run_bits(36);
        repeat (HALF) @(negedge clk);
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL op11_err got %0d exp 1", err_cnt - e0); end
        e0 = err_cnt;
        build(32, OP_WRITE, 5'd0, 5'd3, 2'b00, 16'h1234);
        run_bits(bitq.size());
        repeat (HALF) @(negedge clk);
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL ta_err got %0d exp 1", err_cnt - e0); end
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL err_no_write got %0d exp 0", wr_cnt - w0); end
        write_frame(32, 5'd0, 5'd2, 16'h0042);
        checks++; if (wr_cnt - w0 !== 1 || wr_data !== 16'h0042) begin
            errors++; $display("FAIL post_err_write got %0d/%h exp 1/0042", wr_cnt - w0, wr_data); end
    endtask

    task automatic test_short_preamble();
        logic [16:0] word;
        int tlow, e0, w0;
        e0 = err_cnt; w0 = wr_cnt;
        write_frame(31, 5'd0, 5'd5, 16'h5555);
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL short_pre_write got %0d exp 0", wr_cnt - w0); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL short_pre_err got %0d exp 0", err_cnt - e0); end
        read_frame(32, 5'd0, 5'd5, word, tlow);
        checks++; if (word !== 17'h0) begin errors++; $display("FAIL short_pre_reg got %h exp 0", word); end
    endtask

    task automatic test_read_only();
        logic [16:0] word;
        int tlow, w0, r0;
        w0 = wr_cnt; r0 = rd_cnt;
        write_frame(32, 5'd0, 5'd1, 16'hFFFF);
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL ro_write got %0d exp 0", wr_cnt - w0); end
        read_frame(32, 5'd0, 5'd1, word, tlow);
        checks++; if (word !== 17'h0) begin errors++; $display("FAIL ro_read got %h exp 0", word); end
        checks++; if (rd_cnt - r0 !== 1 || tlow !== 17) begin
            errors++; $display("FAIL ro_read_drive got %0d/%0d exp 1/17", rd_cnt - r0, tlow); end
    endtask

    task automatic test_reset_midframe();
        int r0, w0;
        r0 = rd_cnt;
        build(32, OP_READ, 5'd0, 5'd4, 2'b11, 16'hFFFF);
        run_bits(32 + 24);
        repeat (4) @(negedge clk);
        checks++; if (mdio_t !== 1'b0) begin errors++; $display("FAIL midrst_driving got %b exp 0", mdio_t); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (mdio_t !== 1'b1) begin errors++; $display("FAIL midrst_release got %b exp 1", mdio_t); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ctrl_reg !== 16'h1140) begin errors++; $display("FAIL midrst_ctrl_reg got %h exp 1140", ctrl_reg); end
        checks++; if (rd_cnt - r0 !== 0) begin errors++; $display("FAIL midrst_rd_valid got %0d exp 0", rd_cnt - r0); end
        w0 = wr_cnt;
        write_frame(32, 5'd0, 5'd6, 16'h0F0F);
        checks++; if (wr_cnt - w0 !== 1 || wr_regad !== 5'd6 || wr_data !== 16'h0F0F) begin
            errors++; $display("FAIL midrst_next_frame got %0d/%h/%h exp 1/06/0f0f", wr_cnt - w0, wr_regad, wr_data); end
    endtask

    task automatic test_back_to_back();
        logic [16:0] word;
        int tlow, w0, exp_cnt;
        logic [15:0] exp8;
        exp_cnt = SUP ? 2 : 1;
        exp8 = SUP ? 16'h2222 : 16'h0000;
        w0 = wr_cnt;
        build(32, OP_WRITE, 5'd0, 5'd7, 2'b10, 16'h1111);
        run_bits(bitq.size());
        build(0, OP_WRITE, 5'd0, 5'd8, 2'b10, 16'h2222);
        run_bits(bitq.size());
        repeat (HALF) @(negedge clk);
        checks++; if (wr_cnt - w0 !== exp_cnt) begin
            errors++; $display("FAIL b2b_writes got %0d exp %0d", wr_cnt - w0, exp_cnt); end
        read_frame(32, 5'd0, 5'd7, word, tlow);
        checks++; if (word !== {1'b0, 16'h1111}) begin errors++; $display("FAIL b2b_reg7 got %h exp 01111", word); end
        read_frame(32, 5'd0, 5'd8, word, tlow);
        checks++; if (word !== {1'b0, exp8}) begin errors++; $display("FAIL b2b_reg8 got %h exp %h", word, {1'b0, exp8}); end
    endtask

    initial begin
        test_reset();
        test_write_reg0();
        test_read();
        test_phyad_mismatch();
        test_errors();
        test_short_preamble();
        test_read_only();
        test_reset_midframe();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout reached before summary");
        $fatal(1);
    end

endmodule
